// File: rtl/ts_sync_aligner.sv
// MPEG-TS sync aligner: hunts for 0x47 sync bytes, locks after LOCK_CNT
// consecutive good syncs and forwards whole packets with one cycle of latency.
module ts_sync_aligner #(
   parameter int unsigned PKT_LEN    = 188,
   parameter int unsigned LOCK_CNT   = 3,
   parameter int unsigned UNLOCK_CNT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_d,
   input  logic        in_wrreq,
   output logic [7:0]  out_d,
   output logic        out_wrreq,
   input  logic        out_almost_full,
   output logic        locked,
   output logic        pkt_start,
   output logic [15:0] sync_errors,
   output logic [15:0] dropped_pkts,
   output logic [15:0] pkt_count
);

   localparam int unsigned PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int unsigned GW = $clog2(LOCK_CNT + 1);
   localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);
   localparam logic [7:0]  SYNC = 8'h47;

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pos_q, pos_d, pos_inc;
   logic [GW-1:0]   good_q, good_d;
   logic [BW-1:0]   bad_q, bad_d;
   logic            fwd_q, fwd_d;
   logic            is_sync, pkt_begin;
   logic            fwd_byte, sop, inc_pkt, inc_drop, inc_err;

   assign is_sync = (in_d == SYNC);
   assign pos_inc = (pos_q == PW'(PKT_LEN - 1)) ? '0 : pos_q + PW'(1);

   // Next-state and per-byte decisions; only accepted bytes move anything.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      good_d    = good_q;
      bad_d     = bad_q;
      fwd_d     = fwd_q;
      pkt_begin = 1'b0;
      fwd_byte  = 1'b0;
      sop       = 1'b0;
      inc_pkt   = 1'b0;
      inc_drop  = 1'b0;
      inc_err   = 1'b0;
      if (in_wrreq) begin
         case (state_q)
            HUNT: begin
               if (is_sync) begin
                  pos_d   = PW'(1);
                  good_d  = GW'(1);
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               pos_d = pos_inc;
               if (pos_q == '0) begin
                  if (is_sync) begin
                     if ((32'(good_q) + 32'd1) >= LOCK_CNT) begin
                        state_d   = LOCKED;
                        good_d    = '0;
                        pkt_begin = 1'b1;
                     end else begin
                        good_d = good_q + GW'(1);
                     end
                  end else begin
                     // The failing byte is consumed here, never re-hunted.
                     state_d = HUNT;
                     good_d  = '0;
                     pos_d   = '0;
                  end
               end
            end
            LOCKED: begin
               pos_d = pos_inc;
               if (pos_q == '0) begin
                  if (is_sync) begin
                     pkt_begin = 1'b1;
                  end else begin
                     inc_err = 1'b1;
                     fwd_d   = 1'b0;
                     if ((32'(bad_q) + 32'd1) >= UNLOCK_CNT) begin
                        state_d = HUNT;
                        good_d  = '0;
                        bad_d   = '0;
                        pos_d   = '0;
                     end else begin
                        bad_d    = bad_q + BW'(1);
                        inc_drop = 1'b1;
                     end
                  end
               end else begin
                  fwd_byte = fwd_q;
               end
            end
            default: begin
               state_d = HUNT;
               pos_d   = '0;
               good_d  = '0;
               bad_d   = '0;
               fwd_d   = 1'b0;
            end
         endcase
         // Forward/discard is decided once, at the sync byte, for the whole packet.
         if (pkt_begin) begin
            bad_d    = '0;
            fwd_d    = !out_almost_full;
            fwd_byte = !out_almost_full;
            sop      = !out_almost_full;
            inc_pkt  = !out_almost_full;
            inc_drop = out_almost_full;
         end
      end
   end

   // State register and packet tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HUNT;
         pos_q   <= '0;
         good_q  <= '0;
         bad_q   <= '0;
         fwd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         fwd_q   <= fwd_d;
      end
   end

   // Registered output stage, one cycle behind acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_d     <= '0;
         out_wrreq <= 1'b0;
         pkt_start <= 1'b0;
         locked    <= 1'b0;
      end else begin
         if (in_wrreq) begin
            out_d <= in_d;
         end
         out_wrreq <= fwd_byte;
         pkt_start <= sop;
         locked    <= (state_d == LOCKED);
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_errors  <= '0;
         dropped_pkts <= '0;
         pkt_count    <= '0;
      end else begin
         if (inc_err && sync_errors != 16'hFFFF) begin
            sync_errors <= sync_errors + 16'd1;
         end
         if (inc_drop && dropped_pkts != 16'hFFFF) begin
            dropped_pkts <= dropped_pkts + 16'd1;
         end
         if (inc_pkt && pkt_count != 16'hFFFF) begin
            pkt_count <= pkt_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Bench for ts_sync_aligner: packet-level table plus hand sequences for
// sync loss, back-pressure, gaps and mid-packet reset; forwarded bytes are
// checked against a queue of expected bytes with exact arrival cycles.
module tb_ts_sync_aligner;

   localparam int unsigned PKT_LEN = 188;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_d = 8'h47;
   logic        in_wrreq = 1'b1;
   logic        out_almost_full = 1'b0;
   logic [7:0]  out_d;
   logic        out_wrreq;
   logic        locked;
   logic        pkt_start;
   logic [15:0] sync_errors;
   logic [15:0] dropped_pkts;
   logic [15:0] pkt_count;

   ts_sync_aligner #(.PKT_LEN(PKT_LEN), .LOCK_CNT(3), .UNLOCK_CNT(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_d            (in_d),
      .in_wrreq        (in_wrreq),
      .out_d           (out_d),
      .out_wrreq       (out_wrreq),
      .out_almost_full (out_almost_full),
      .locked          (locked),
      .pkt_start       (pkt_start),
      .sync_errors     (sync_errors),
      .dropped_pkts    (dropped_pkts),
      .pkt_count       (pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         sop;
      int         due;
   } exp_t;

   typedef struct {
      bit sync_ok;
      bit af_start;
      int af_at;
      bit gaps;
      bit exp_fwd;
      bit exp_lock;
      int exp_pkt;
      int exp_drop;
      int exp_err;
   } row_t;

   exp_t q[$];
   row_t tbl[9];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   lk_pend = 1'b0;
   bit   lk_exp  = 1'b0;

   function automatic logic [7:0] rnd_ns();
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'h47) b = 8'h46;
      return b;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare outputs seen this cycle against the expected-byte queue.
   task automatic monitor();
      exp_t e;
      if (pkt_start === 1'b1 && out_wrreq !== 1'b1) check("pkt_start_without_wrreq", 1, 0);
      if (out_wrreq === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_out_wrreq", 1, 0);
         end else begin
            e = q.pop_front();
            tests++;
            if (out_d !== e.d || pkt_start !== e.sop || cyc != e.due) begin
               fails++;
               $display("FAIL out_byte: got d=%02h sop=%0d cyc=%0d expected d=%02h sop=%0d cyc=%0d",
                        out_d, pkt_start, cyc, e.d, e.sop, e.due);
            end
         end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         check("missing_out_byte", 0, 1);
      end
      if (lk_pend) begin
         check("locked_after_sync", int'(locked), int'(lk_exp));
         lk_pend = 1'b0;
      end
   endtask

   task automatic step(input bit rst, input bit wr, input logic [7:0] d,
                       input bit af, input bit exp, input bit sop);
      exp_t e;
      @(negedge clk);
      cyc++;
      monitor();
      reset           = rst;
      in_wrreq        = wr;
      in_d            = d;
      out_almost_full = af;
      if (exp) begin
         e.d   = d;
         e.sop = sop;
         e.due = cyc + 1;
         q.push_back(e);
      end
   endtask

   task automatic send_pkt(input bit sync_ok, input bit af_start, input int af_at,
                           input bit gaps, input bit exp_fwd, input bit exp_lock);
      logic [7:0] d;
      bit         af;
      for (int i = 0; i < int'(PKT_LEN); i++) begin
         d  = (i == 0 && sync_ok) ? 8'h47 : rnd_ns();
         af = (af_at != 0 && i >= af_at) ? !af_start : af_start;
         if (gaps && $urandom_range(0, 1) == 1) step(1'b0, 1'b0, 8'($urandom_range(0, 255)), af, 1'b0, 1'b0);
         step(1'b0, 1'b1, d, af, exp_fwd, (i == 0));
         if (i == 0) begin
            lk_pend = 1'b1;
            lk_exp  = exp_lock;
         end
      end
   endtask

   task automatic chk_counters(input int p, input int dr, input int er);
      check("pkt_count", int'(pkt_count), p);
      check("dropped_pkts", int'(dropped_pkts), dr);
      check("sync_errors", int'(sync_errors), er);
   endtask

   initial begin
      //          sync af  at   gap fwd lock pkt drop err
      tbl[0] = '{1, 0,   0, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 0,   0, 0, 0, 0, 0, 0, 0};
      tbl[2] = '{1, 0,   0, 0, 1, 1, 1, 0, 0};
      tbl[3] = '{1, 0,   0, 1, 1, 1, 2, 0, 0};
      tbl[4] = '{1, 0,   0, 0, 1, 1, 3, 0, 0};
      tbl[5] = '{1, 1,   5, 0, 0, 1, 3, 1, 0};
      tbl[6] = '{1, 0, 100, 1, 1, 1, 4, 1, 0};
      tbl[7] = '{0, 0,   0, 0, 0, 1, 4, 2, 1};
      tbl[8] = '{1, 0,   0, 0, 1, 1, 5, 2, 1};

      // Reset held while sync bytes are offered: reset must win.
      step(1'b1, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("reset_locked", int'(locked), 0);
      check("reset_out_wrreq", int'(out_wrreq), 0);
      check("reset_pkt_start", int'(pkt_start), 0);
      check("reset_out_d", int'(out_d), 0);
      chk_counters(0, 0, 0);

      for (int r = 0; r < 9; r++) begin
         send_pkt(tbl[r].sync_ok, tbl[r].af_start, tbl[r].af_at, tbl[r].gaps,
                  tbl[r].exp_fwd, tbl[r].exp_lock);
         step(1'b0, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0);
         chk_counters(tbl[r].exp_pkt, tbl[r].exp_drop, tbl[r].exp_err);
      end

      // Ten inserted junk bytes shift the stream: one drop, then unlock, then relock.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, rnd_ns(), 1'b0, 1'b0, 1'b0);
      send_pkt(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("unlocked_after_2nd_miss", int'(locked), 0);
      chk_counters(5, 3, 3);
      send_pkt(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      send_pkt(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      send_pkt(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
      send_pkt(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_counters(7, 3, 3);

      // Reset at byte 50 of a forwarded packet.
      for (int i = 0; i < 50; i++) begin
         step(1'b0, 1'b1, (i == 0) ? 8'h47 : rnd_ns(), 1'b0, 1'b1, (i == 0));
      end
      step(1'b1, 1'b1, rnd_ns(), 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, rnd_ns(), 1'b0, 1'b0, 1'b0);
      check("midpkt_reset_out_wrreq", int'(out_wrreq), 0);
      check("midpkt_reset_locked", int'(locked), 0);
      chk_counters(0, 0, 0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rnd_ns(), 1'b0, 1'b0, 1'b0);
      send_pkt(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      send_pkt(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      send_pkt(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);

      repeat (4) step(1'b0, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0);
      chk_counters(1, 0, 0);
      check("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
